// File: rtl/oldland_mem_pkg.sv
// Shared encodings for the oldland memory controller: access widths,
// fault causes, FSM states and the alignment rule for requests.
package oldland_mem_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_BUS      = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

  // Width code 11 is handled as a word, so any width with bit 1 set needs word alignment.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] offset);
    return ((width == WIDTH_HALF) && offset[0]) || (width[1] && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/oldland_mem_align.sv
// Byte-lane steering: byte enables and write-data rotation for requests,
// read-data extraction with optional sign extension for responses.
module oldland_mem_align
  import oldland_mem_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic [1:0]  offset_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] rd_data_i,
  output logic [3:0]  bytesel_o,
  output logic [31:0] wr_lane_o,
  output logic [31:0] rd_val_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    bytesel_o = 4'b1111;
    wr_lane_o = wr_data_i;
    rd_val_o  = rd_data_i;
    byte_v    = 8'(rd_data_i >> {offset_i, 3'b000});
    half_v    = 16'(rd_data_i >> {offset_i[1], 4'b0000});
    case (width_i)
      WIDTH_BYTE: begin
        bytesel_o = 4'b0001 << offset_i;
        wr_lane_o = wr_data_i << {offset_i, 3'b000};
        rd_val_o  = {{24{sign_ext_i & byte_v[7]}}, byte_v};
      end
      WIDTH_HALF: begin
        bytesel_o = offset_i[1] ? 4'b1100 : 4'b0011;
        wr_lane_o = wr_data_i << {offset_i[1], 4'b0000};
        rd_val_o  = {{16{sign_ext_i & half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/oldland_memory_ctl.sv
// Registered memory stage: holds each load/store as a data-bus transaction
// until acknowledged, stalling the pipeline, and reports misalign/bus/timeout faults.
module oldland_memory_ctl
  import oldland_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int RD_SEL_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    store,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [31:0]             mdr,
  input  logic [1:0]              width,
  input  logic                    sign_ext,
  input  logic [31:0]             wr_val,
  input  logic                    update_rd,
  input  logic [RD_SEL_WIDTH-1:0] rd_sel,
  output logic [31:0]             reg_wr_val,
  output logic                    update_rd_out,
  output logic [RD_SEL_WIDTH-1:0] rd_sel_out,
  output logic                    complete,
  output logic                    stall,
  output logic                    fault,
  output logic [1:0]              fault_cause,
  output logic [ADDR_WIDTH-1:0]   fault_addr,
  output logic [ADDR_WIDTH-1:0]   d_addr,
  output logic [3:0]              d_bytesel,
  output logic                    d_wr_en,
  output logic [31:0]             d_wr_val,
  input  logic [31:0]             d_data,
  output logic                    d_access,
  input  logic                    d_ack,
  input  logic                    d_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   d_addr_q, d_addr_d;
  logic [3:0]              d_bytesel_q, d_bytesel_d;
  logic [31:0]             d_wr_val_q, d_wr_val_d;
  logic                    d_wr_en_q, d_wr_en_d;
  logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
  logic                    lat_load_q, lat_load_d;
  logic [1:0]              lat_width_q, lat_width_d;
  logic                    lat_sext_q, lat_sext_d;
  logic [RD_SEL_WIDTH-1:0] lat_rd_q, lat_rd_d;
  logic [31:0]             reg_wr_val_q, reg_wr_val_d;
  logic                    update_rd_out_q, update_rd_out_d;
  logic [RD_SEL_WIDTH-1:0] rd_sel_out_q, rd_sel_out_d;
  logic                    complete_q, complete_d;
  logic                    fault_q, fault_d;
  logic [1:0]              fault_cause_q, fault_cause_d;
  logic [ADDR_WIDTH-1:0]   fault_addr_q, fault_addr_d;

  logic        req, in_bus, accept, mis_fault, bypass, bus_err, bus_ack, bus_to;
  logic [3:0]  req_bytesel;
  logic [31:0] req_wr_lane, rsp_rd_val;
  logic [31:0] req_rd_unused, rsp_wr_unused;
  logic [3:0]  rsp_bytesel_unused;

  oldland_mem_align u_req_align (
    .width_i    (width),
    .offset_i   (addr[1:0]),
    .sign_ext_i (sign_ext),
    .wr_data_i  (mdr),
    .rd_data_i  (32'h0),
    .bytesel_o  (req_bytesel),
    .wr_lane_o  (req_wr_lane),
    .rd_val_o   (req_rd_unused)
  );

  // Response path decodes the read lane from the fields latched at accept time.
  oldland_mem_align u_rsp_align (
    .width_i    (lat_width_q),
    .offset_i   (lat_addr_q[1:0]),
    .sign_ext_i (lat_sext_q),
    .wr_data_i  (32'h0),
    .rd_data_i  (d_data),
    .bytesel_o  (rsp_bytesel_unused),
    .wr_lane_o  (rsp_wr_unused),
    .rd_val_o   (rsp_rd_val)
  );

  assign req       = load | store;
  assign in_bus    = (state_q == BUS);
  assign accept    = !in_bus && req && !misaligned(width, addr[1:0]);
  assign mis_fault = !in_bus && req && misaligned(width, addr[1:0]);
  assign bypass    = !in_bus && !req;
  assign bus_err   = in_bus && d_error;
  assign bus_ack   = in_bus && !d_error && d_ack;
  assign bus_to    = in_bus && !d_error && !d_ack && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    stall   = req;
    case (state_q)
      IDLE: if (accept) state_d = BUS;
      BUS: begin
        stall = 1'b1;
        if (bus_err || bus_ack || bus_to) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d           = cnt_q;
    d_addr_d        = d_addr_q;
    d_bytesel_d     = d_bytesel_q;
    d_wr_val_d      = d_wr_val_q;
    d_wr_en_d       = d_wr_en_q;
    lat_addr_d      = lat_addr_q;
    lat_load_d      = lat_load_q;
    lat_width_d     = lat_width_q;
    lat_sext_d      = lat_sext_q;
    lat_rd_d        = lat_rd_q;
    reg_wr_val_d    = reg_wr_val_q;
    rd_sel_out_d    = rd_sel_out_q;
    update_rd_out_d = 1'b0;
    complete_d      = 1'b0;
    fault_d         = 1'b0;
    fault_cause_d   = FAULT_NONE;
    fault_addr_d    = fault_addr_q;

    if (bypass) begin
      reg_wr_val_d    = wr_val;
      update_rd_out_d = update_rd;
      rd_sel_out_d    = rd_sel;
    end
    if (mis_fault) begin
      fault_d       = 1'b1;
      fault_cause_d = FAULT_MISALIGN;
      fault_addr_d  = addr;
    end
    if (accept) begin
      cnt_d       = '0;
      d_addr_d    = {addr[ADDR_WIDTH-1:2], 2'b00};
      d_bytesel_d = req_bytesel;
      d_wr_val_d  = req_wr_lane;
      d_wr_en_d   = store;
      lat_addr_d  = addr;
      lat_load_d  = load;
      lat_width_d = width;
      lat_sext_d  = sign_ext;
      lat_rd_d    = rd_sel;
    end
    if (in_bus) cnt_d = cnt_q + 1'b1;
    if (bus_err) begin
      fault_d       = 1'b1;
      fault_cause_d = FAULT_BUS;
      fault_addr_d  = lat_addr_q;
    end
    if (bus_ack) begin
      complete_d      = 1'b1;
      update_rd_out_d = lat_load_q;
      rd_sel_out_d    = lat_rd_q;
      reg_wr_val_d    = rsp_rd_val;
    end
    if (bus_to) begin
      fault_d       = 1'b1;
      fault_cause_d = FAULT_TIMEOUT;
      fault_addr_d  = lat_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      d_addr_q        <= '0;
      d_bytesel_q     <= '0;
      d_wr_val_q      <= '0;
      d_wr_en_q       <= 1'b0;
      lat_addr_q      <= '0;
      lat_load_q      <= 1'b0;
      lat_width_q     <= '0;
      lat_sext_q      <= 1'b0;
      lat_rd_q        <= '0;
      reg_wr_val_q    <= '0;
      update_rd_out_q <= 1'b0;
      rd_sel_out_q    <= '0;
      complete_q      <= 1'b0;
      fault_q         <= 1'b0;
      fault_cause_q   <= FAULT_NONE;
      fault_addr_q    <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      d_addr_q        <= d_addr_d;
      d_bytesel_q     <= d_bytesel_d;
      d_wr_val_q      <= d_wr_val_d;
      d_wr_en_q       <= d_wr_en_d;
      lat_addr_q      <= lat_addr_d;
      lat_load_q      <= lat_load_d;
      lat_width_q     <= lat_width_d;
      lat_sext_q      <= lat_sext_d;
      lat_rd_q        <= lat_rd_d;
      reg_wr_val_q    <= reg_wr_val_d;
      update_rd_out_q <= update_rd_out_d;
      rd_sel_out_q    <= rd_sel_out_d;
      complete_q      <= complete_d;
      fault_q         <= fault_d;
      fault_cause_q   <= fault_cause_d;
      fault_addr_q    <= fault_addr_d;
    end
  end

  // d_access follows the state register so an async reset drops it at once.
  assign d_access      = in_bus;
  assign d_addr        = d_addr_q;
  assign d_bytesel     = d_bytesel_q;
  assign d_wr_val      = d_wr_val_q;
  assign d_wr_en       = d_wr_en_q;
  assign reg_wr_val    = reg_wr_val_q;
  assign update_rd_out = update_rd_out_q;
  assign rd_sel_out    = rd_sel_out_q;
  assign complete      = complete_q;
  assign fault         = fault_q;
  assign fault_cause   = fault_cause_q;
  assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_oldland_memory_ctl.sv
// Directed bench for oldland_memory_ctl: a vector table of single-ack
// transactions plus hand sequences for stalls, faults, timeout and reset.
module tb_oldland_memory_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load, store, sign_ext, update_rd, d_ack, d_error;
  logic [31:0] addr, mdr, wr_val, d_data;
  logic [1:0]  width;
  logic [2:0]  rd_sel;
  logic [31:0] reg_wr_val, fault_addr, d_addr, d_wr_val;
  logic        update_rd_out, complete, stall, fault, d_wr_en, d_access;
  logic [2:0]  rd_sel_out;
  logic [1:0]  fault_cause;
  logic [3:0]  d_bytesel;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  oldland_memory_ctl #(
    .ADDR_WIDTH(32), .RD_SEL_WIDTH(3), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .store(store), .addr(addr), .mdr(mdr),
    .width(width), .sign_ext(sign_ext), .wr_val(wr_val), .update_rd(update_rd),
    .rd_sel(rd_sel), .reg_wr_val(reg_wr_val), .update_rd_out(update_rd_out),
    .rd_sel_out(rd_sel_out), .complete(complete), .stall(stall), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr), .d_addr(d_addr),
    .d_bytesel(d_bytesel), .d_wr_en(d_wr_en), .d_wr_val(d_wr_val), .d_data(d_data),
    .d_access(d_access), .d_ack(d_ack), .d_error(d_error)
  );

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] mdr;
    logic [1:0]  width;
    logic        sx;
    logic [31:0] ddata;
    logic [3:0]  bsel;
    logic [31:0] daddr;
    logic [31:0] wval;
    logic [31:0] rval;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic ld, input logic st, input logic [31:0] a,
                     input logic [1:0] w, input logic sx, input logic [31:0] m);
    load = ld; store = st; addr = a; width = w; sign_ext = sx; mdr = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    vecs[0]  = {1'b1, 1'b0, 32'h1003, 32'h0,        2'b00, 1'b1, 32'h80FF_FF00, 4'b1000, 32'h1000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = {1'b0, 1'b1, 32'h2002, 32'h0000_BEEF, 2'b01, 1'b0, 32'h0,        4'b1100, 32'h2000, 32'hBEEF_0000, 32'h0};
    vecs[2]  = {1'b1, 1'b0, 32'h1001, 32'h0,        2'b00, 1'b0, 32'h1234_A678, 4'b0010, 32'h1000, 32'h0,        32'h0000_00A6};
    vecs[3]  = {1'b1, 1'b0, 32'h4000, 32'h0,        2'b01, 1'b1, 32'h0000_8001, 4'b0011, 32'h4000, 32'h0,        32'hFFFF_8001};
    vecs[4]  = {1'b1, 1'b0, 32'h4002, 32'h0,        2'b01, 1'b0, 32'h8001_0000, 4'b1100, 32'h4000, 32'h0,        32'h0000_8001};
    vecs[5]  = {1'b1, 1'b0, 32'h5004, 32'h0,        2'b10, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h5004, 32'h0,        32'hDEAD_BEEF};
    vecs[6]  = {1'b1, 1'b0, 32'h5008, 32'h0,        2'b11, 1'b1, 32'h8000_0000, 4'b1111, 32'h5008, 32'h0,        32'h8000_0000};
    vecs[7]  = {1'b0, 1'b1, 32'h6002, 32'h1234_56AB, 2'b00, 1'b0, 32'h0,        4'b0100, 32'h6000, 32'h56AB_0000, 32'h0};
    vecs[8]  = {1'b0, 1'b1, 32'h7000, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0,        4'b1111, 32'h7000, 32'hCAFE_F00D, 32'h0};
    vecs[9]  = {1'b1, 1'b0, 32'h1000, 32'h0,        2'b00, 1'b1, 32'h0000_007F, 4'b0001, 32'h1000, 32'h0,        32'h0000_007F};
    vecs[10] = {1'b1, 1'b0, 32'h4002, 32'h0,        2'b01, 1'b1, 32'h7FFF_1234, 4'b1100, 32'h4000, 32'h0,        32'h0000_7FFF};

    rst_n = 1'b0;
    req(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    wr_val = 32'h0; update_rd = 1'b0; rd_sel = 3'd0;
    d_ack = 1'b0; d_error = 1'b0; d_data = 32'h0;
    #12;
    chk("rst_d_access", 32'(d_access), 32'h0);
    chk("rst_complete", 32'(complete), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_fault_cause", 32'(fault_cause), 32'h0);
    chk("rst_reg_wr_val", reg_wr_val, 32'h0);
    chk("rst_update_rd_out", 32'(update_rd_out), 32'h0);
    chk("rst_d_bytesel", 32'(d_bytesel), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bypass, then hold while stalled
    wr_val = 32'h1111_2222; update_rd = 1'b1; rd_sel = 3'd3;
    tick();
    chk("byp_val", reg_wr_val, 32'h1111_2222);
    chk("byp_upd", 32'(update_rd_out), 32'h1);
    chk("byp_rdsel", 32'(rd_sel_out), 32'h3);
    req(1'b1, 1'b0, 32'hC000, 2'b10, 1'b0, 32'h0);
    wr_val = 32'h9999_9999;
    tick();
    chk("hold_upd", 32'(update_rd_out), 32'h0);
    chk("hold_val", reg_wr_val, 32'h1111_2222);
    load = 1'b0; update_rd = 1'b0; d_ack = 1'b1; d_data = 32'h0;
    tick();
    d_ack = 1'b0;
    tick();

    // Vector table: accept, one BUS cycle acked, completion
    for (int i = 0; i < 11; i++) begin
      req(vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].width, vecs[i].sx, vecs[i].mdr);
      rd_sel = 3'd5;
      #1;
      chk($sformatf("v%0d_stall_req", i), 32'(stall), 32'h1);
      tick();
      load = 1'b0; store = 1'b0;
      chk($sformatf("v%0d_d_access", i), 32'(d_access), 32'h1);
      chk($sformatf("v%0d_d_addr", i), d_addr, vecs[i].daddr);
      chk($sformatf("v%0d_bytesel", i), 32'(d_bytesel), 32'(vecs[i].bsel));
      chk($sformatf("v%0d_wr_val", i), d_wr_val, vecs[i].wval);
      chk($sformatf("v%0d_wr_en", i), 32'(d_wr_en), 32'(vecs[i].st));
      d_ack = 1'b1; d_data = vecs[i].ddata;
      tick();
      d_ack = 1'b0;
      chk($sformatf("v%0d_complete", i), 32'(complete), 32'h1);
      chk($sformatf("v%0d_fault", i), 32'(fault), 32'h0);
      chk($sformatf("v%0d_upd", i), 32'(update_rd_out), 32'(vecs[i].ld));
      chk($sformatf("v%0d_d_access_off", i), 32'(d_access), 32'h0);
      chk($sformatf("v%0d_stall_off", i), 32'(stall), 32'h0);
      if (vecs[i].ld) begin
        chk($sformatf("v%0d_rval", i), reg_wr_val, vecs[i].rval);
        chk($sformatf("v%0d_rdsel", i), 32'(rd_sel_out), 32'h5);
      end
    end
    tick();

    // Signed byte load acked on the second BUS cycle; stall spans three cycles
    n = 0;
    req(1'b1, 1'b0, 32'h1003, 2'b00, 1'b1, 32'h0);
    rd_sel = 3'd2;
    #1; if (stall) n++;
    tick(); if (stall) n++;
    chk("sb_d_access1", 32'(d_access), 32'h1);
    tick(); if (stall) n++;
    chk("sb_complete_early", 32'(complete), 32'h0);
    d_ack = 1'b1; d_data = 32'h80FF_FF00;
    tick();
    d_ack = 1'b0; load = 1'b0;
    #1;
    chk("sb_complete", 32'(complete), 32'h1);
    chk("sb_val", reg_wr_val, 32'hFFFF_FF80);
    chk("sb_upd", 32'(update_rd_out), 32'h1);
    chk("sb_rdsel", 32'(rd_sel_out), 32'h2);
    chk("sb_stall_now", 32'(stall), 32'h0);
    chk("sb_stall_cycles", 32'(n), 32'h3);
    tick();

    // Misaligned word load
    req(1'b1, 1'b0, 32'h3001, 2'b10, 1'b0, 32'h0);
    #1;
    chk("mis_stall", 32'(stall), 32'h1);
    tick();
    load = 1'b0;
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_cause", 32'(fault_cause), 32'h1);
    chk("mis_addr", fault_addr, 32'h3001);
    chk("mis_d_access", 32'(d_access), 32'h0);
    chk("mis_upd", 32'(update_rd_out), 32'h0);
    tick();
    chk("mis_d_access2", 32'(d_access), 32'h0);
    chk("mis_fault_pulse", 32'(fault), 32'h0);

    // Ack and error together: error wins
    req(1'b0, 1'b1, 32'h8000, 2'b10, 1'b0, 32'h1234_5678);
    tick();
    store = 1'b0;
    d_ack = 1'b1; d_error = 1'b1;
    tick();
    d_ack = 1'b0; d_error = 1'b0;
    chk("err_fault", 32'(fault), 32'h1);
    chk("err_cause", 32'(fault_cause), 32'h2);
    chk("err_addr", fault_addr, 32'h8000);
    chk("err_complete", 32'(complete), 32'h0);
    chk("err_d_access", 32'(d_access), 32'h0);
    chk("err_upd", 32'(update_rd_out), 32'h0);
    tick();

    // Timeout after four unacknowledged BUS cycles, late ack ignored
    req(1'b1, 1'b0, 32'h9000, 2'b10, 1'b0, 32'h0);
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_d_access%0d", k), 32'(d_access), 32'h1);
      chk($sformatf("to_nofault%0d", k), 32'(fault), 32'h0);
      tick();
    end
    chk("to_d_access_off", 32'(d_access), 32'h0);
    chk("to_fault", 32'(fault), 32'h1);
    chk("to_cause", 32'(fault_cause), 32'h3);
    chk("to_addr", fault_addr, 32'h9000);
    d_ack = 1'b1; d_data = 32'hFFFF_FFFF;
    tick();
    d_ack = 1'b0;
    chk("late_complete", 32'(complete), 32'h0);
    chk("late_fault", 32'(fault), 32'h0);
    chk("late_d_access", 32'(d_access), 32'h0);

    // Back-to-back: load accepted in the store's complete cycle
    req(1'b0, 1'b1, 32'hA000, 2'b10, 1'b0, 32'h0102_0304);
    tick();
    store = 1'b0;
    d_ack = 1'b1;
    tick();
    d_ack = 1'b0;
    req(1'b1, 1'b0, 32'hA004, 2'b10, 1'b0, 32'h0);
    rd_sel = 3'd6;
    #1;
    chk("b2b_complete1", 32'(complete), 32'h1);
    chk("b2b_upd1", 32'(update_rd_out), 32'h0);
    chk("b2b_stall", 32'(stall), 32'h1);
    tick();
    load = 1'b0;
    chk("b2b_d_access", 32'(d_access), 32'h1);
    chk("b2b_d_addr", d_addr, 32'hA004);
    chk("b2b_wr_en", 32'(d_wr_en), 32'h0);
    chk("b2b_complete_gap", 32'(complete), 32'h0);
    d_ack = 1'b1; d_data = 32'h55AA_55AA;
    tick();
    d_ack = 1'b0;
    chk("b2b_complete2", 32'(complete), 32'h1);
    chk("b2b_val", reg_wr_val, 32'h55AA_55AA);
    chk("b2b_rdsel", 32'(rd_sel_out), 32'h6);

    // Ack and error in IDLE are ignored
    tick();
    d_ack = 1'b1; d_error = 1'b1;
    tick();
    d_ack = 1'b0; d_error = 1'b0;
    chk("idle_ack_complete", 32'(complete), 32'h0);
    chk("idle_ack_fault", 32'(fault), 32'h0);
    chk("idle_ack_d_access", 32'(d_access), 32'h0);

    // Asynchronous reset in the middle of a bus access
    req(1'b1, 1'b0, 32'hB000, 2'b10, 1'b0, 32'h0);
    tick();
    load = 1'b0;
    chk("rstm_d_access_pre", 32'(d_access), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_d_access", 32'(d_access), 32'h0);
    chk("rstm_complete", 32'(complete), 32'h0);
    chk("rstm_fault", 32'(fault), 32'h0);
    d_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    d_ack = 1'b0;
    chk("rstm_complete_after", 32'(complete), 32'h0);
    chk("rstm_fault_after", 32'(fault), 32'h0);
    chk("rstm_d_access_after", 32'(d_access), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oldland_memory_ctl.md
Name: oldland_memory_ctl

Overview:
- Parametrised, registered successor to the pipeline memory stage.
- Holds each load or store as a bus transaction until the data bus acknowledges it, and stalls the pipeline meanwhile.
- Adds signed sub-word loads, misalignment detection, bus-error reporting and a watchdog timeout.
- Sits between execute and writeback; drives the data bus directly.

Parameters:
- ADDR_WIDTH, 32, byte address width; d_addr is word-aligned.
- RD_SEL_WIDTH, 3, destination register index width.
- TIMEOUT_CYCLES, 256, cycles in BUS without d_ack before a timeout fault; must be at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load, store  in  1 each  request strobes; mutually exclusive.
- addr  in  ADDR_WIDTH  byte address.
- mdr  in  32  store data, right-aligned.
- width  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- sign_ext  in  1  sign-extend byte/half loads.
- wr_val  in  32  non-memory result to bypass.
- update_rd, rd_sel  in  1, RD_SEL_WIDTH  writeback request to bypass.
- reg_wr_val  out  32  writeback value.
- update_rd_out, rd_sel_out  out  1, RD_SEL_WIDTH  writeback control.
- complete  out  1  one-cycle pulse when a bus access finishes without fault.
- stall  out  1  pipeline must hold its inputs.
- fault  out  1  one-cycle fault pulse.
- fault_cause  out  2  01 misaligned, 10 bus error, 11 timeout.
- fault_addr  out  ADDR_WIDTH  address of the faulting access.
- d_addr  out  ADDR_WIDTH  bus address.
- d_bytesel  out  4  byte enables.
- d_wr_en  out  1  bus write.
- d_wr_val  out  32  lane-rotated write data.
- d_data  in  32  bus read data.
- d_access  out  1  bus request.
- d_ack, d_error  in  1 each  bus completion and bus error.

Behaviour:
- Reset: FSM to IDLE. All outputs 0; the timeout counter and all latched fields are 0. Reset is asynchronous, so a reset asserted during BUS drops d_access immediately and produces neither complete nor fault.
- States:
  - IDLE: stall = load|store (combinational).
    - If load|store and misaligned (half with addr[0]=1, or word/11 with addr[1:0]≠0): next cycle fault=1, fault_cause=01, fault_addr=addr, no bus access, and update_rd_out=0. Remain in IDLE.
    - Otherwise: latch d_addr={addr[ADDR_WIDTH-1:2],00}, d_bytesel, d_wr_val, d_wr_en=store, rd_sel, load flag, width, sign_ext and addr[1:0]. Clear the timeout counter and go to BUS. d_access is 1 from the next cycle.
  - BUS: stall=1; d_access=1; the counter increments every cycle. Exits are checked in priority order:
    - d_error (wins over a simultaneous d_ack): next cycle fault=1, fault_cause=10, fault_addr = latched address, update_rd_out=0, d_access=0, go to IDLE.
    - d_ack: capture the aligned read value. Next cycle complete=1, update_rd_out=latched load flag, rd_sel_out=latched rd_sel, reg_wr_val=captured value, d_access=0, go to IDLE.
    - counter = TIMEOUT_CYCLES-1 with no ack: next cycle fault=1, fault_cause=11, d_access=0, go to IDLE. A d_ack arriving after the timeout is ignored.
  - stall is 0 in the cycle after d_ack. A new request is accepted in the same cycle that complete is pulsed, so back-to-back accesses are supported.
- Lane rules:
  - Byte: bytesel = 0001<<addr[1:0]; write data = mdr<<(8·addr[1:0]); read data = (d_data>>(8·addr[1:0]))[7:0].
  - Half: bytesel = 0011<<(2·addr[1]); shifts by 16·addr[1]; read data is 16 bits.
  - Word: bytesel 1111; no shift.
  - Loads zero-extend, or sign-extend from bit 7 or bit 15 when sign_ext=1.
- Bypass: when stall=0 and no memory completion is pending, register wr_val, update_rd and rd_sel onto reg_wr_val, update_rd_out and rd_sel_out every cycle. While stall=1 the bypass registers hold their values and update_rd_out=0.
- d_ack or d_error received in IDLE is ignored.
- fault and complete are never both 1.

Decomposition:
- Package oldland_mem_pkg holds:
  - width codes WIDTH_BYTE, WIDTH_HALF, WIDTH_WORD;
  - fault causes FAULT_NONE, FAULT_MISALIGN, FAULT_BUS, FAULT_TIMEOUT;
  - the state enum IDLE and BUS.
- One combinational sub-module, oldland_mem_align, computes bytesel, the write-data rotation and the read extract/extend from width, addr[1:0] and sign_ext. It is instantiated once for the request path and once for the response path.

Test Plan:
- Signed byte load, addr=0x1003, sign_ext=1, ack on the 2nd BUS cycle, d_data=0x80FF_FF00 -> d_bytesel=1000, d_addr=0x1000, complete at ack+1, reg_wr_val=0xFFFF_FF80, update_rd_out=1, stall high for 3 cycles.
- Half store, addr=0x2002, mdr=0x0000_BEEF -> d_bytesel=1100, d_wr_val=0xBEEF_0000, d_wr_en=1, complete with update_rd_out=0.
- Word load at addr=0x3001 -> fault=1, fault_cause=01, fault_addr=0x3001, d_access never asserted.
- d_ack and d_error both asserted in the same BUS cycle -> fault_cause=10, complete=0, d_access low the next cycle.
- TIMEOUT_CYCLES=4 with no ack -> d_access high for exactly 4 cycles, then fault_cause=11; a late d_ack is ignored.
- Back-to-back: a load is accepted in the complete cycle of a prior store -> new d_access the next cycle. Also assert rst_n mid-BUS -> d_access=0 asynchronously, no complete and no fault.
